gba_cheat_engine: RTL and testbench

Consumer end of the cheat-code loader path. It latches 129-bit code words (clock bit plus flags, address, compare and replace fields) into a slot table, then patches read data on its way back to the GBA core. It sits between the SDRAM read return path (ROM channel) and the core's read-data input. It sees every returned dword with its address and substitutes matching byte lanes.

---
 rtl/gba_cheat_engine_pkg.sv | 54 +++++
 rtl/gba_cheat_engine_if.sv | 26 ++
 rtl/gba_cheat_engine_slot.sv | 67 ++++++
 rtl/gba_cheat_engine.sv | 184 ++++++++++++++++++
 tb/tb_gba_cheat_engine.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gba_cheat_engine_pkg.sv
// gba_cheat_pkg: shared definitions for the cheat engine.
//   - code word field offsets within the 129-bit code_in bus
//   - code width encoding (cw_e) and slot contents (slot_t)
//   - lane helpers: lanemask, lane_shift, byte_mask
package gba_cheat_pkg;

  localparam int CODE_CLK       = 128;
  localparam int CODE_FLAGS_LSB = 96;
  localparam int CODE_ADDR_LSB  = 64;
  localparam int CODE_CMP_LSB   = 32;
  localparam int CODE_REP_LSB   = 0;
  localparam int FLAG_CMP_EN    = 0;
  localparam int FLAG_W_LSB     = 1;

  typedef enum logic [1:0] {
    CW_BYTE = 2'd0,
    CW_HALF = 2'd1,
    CW_WORD = 2'd2,
    CW_BAD  = 2'd3
  } cw_e;

  typedef struct packed {
    logic        valid;
    logic [27:0] addr;
    cw_e         width;
    logic        cmp_en;
    logic [31:0] compare;
    logic [31:0] replace;
  } slot_t;

  // Byte lanes touched by a code of width w at byte offset a.
  function automatic logic [3:0] lanemask(cw_e w, logic [1:0] a);
    case (w)
      CW_BYTE: lanemask = 4'b0001 << a;
      CW_HALF: lanemask = a[1] ? 4'b1100 : 4'b0011;
      CW_WORD: lanemask = 4'b1111;
      default: lanemask = 4'b0000;
    endcase
  endfunction

  // Bit shift that moves a right-aligned value into its lane position.
  function automatic logic [4:0] lane_shift(cw_e w, logic [1:0] a);
    case (w)
      CW_BYTE: lane_shift = {a, 3'b000};
      CW_HALF: lane_shift = {a[1], 4'b0000};
      default: lane_shift = 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] byte_mask(logic [3:0] l);
    byte_mask = {{8{l[3]}}, {8{l[2]}}, {8{l[1]}}, {8{l[0]}}};
  endfunction

endpackage

// File: rtl/gba_cheat_engine_if.sv
// gba_cheat_engine_if: ROM read-return path into the engine and the patched
// stream out of it.
//   rd_valid/rd_addr/rd_data : returned dword from SDRAM (source -> engine)
//   out_valid/out_data       : patched dword to the GBA core (engine -> sink)
// Handshake: valid-only streaming. A beat transfers on every clock edge where
// its valid is high; there is no ready/stall, so the consumer must accept
// every cycle.
interface gba_cheat_engine_if #(
  parameter int ADDR_W = 26
);
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              out_valid;
  logic [31:0]       out_data;

  modport master (
    output rd_valid, rd_addr, rd_data,
    input  out_valid, out_data
  );

  modport slave (
    input  rd_valid, rd_addr, rd_data,
    output out_valid, out_data
  );
endinterface

// File: rtl/gba_cheat_engine_slot.sv
// gba_cheat_slot: one entry of the cheat table.
//   clk_sys/reset_n : clock, synchronous active-low reset
//   i_clear         : invalidate this entry
//   i_wr            : store the presented code (already validated by the top)
//   i_code_*        : fields of the code being loaded
//   i_enable        : global cheat enable, gates o_hit
//   i_rd_addr/data  : beat entering the pipeline
//   o_match         : entry is valid and holds the same addr[27:0] and width
//   o_hit           : entry patches the current beat
//   o_lanes         : byte lanes this entry covers
//   o_replace       : replace value shifted into lane position
module gba_cheat_slot
  import gba_cheat_pkg::*;
#(
  parameter int ADDR_W = 26
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_wr,
  input  logic [27:0]       i_code_addr,
  input  cw_e               i_code_width,
  input  logic              i_code_cmp_en,
  input  logic [31:0]       i_code_compare,
  input  logic [31:0]       i_code_replace,
  input  logic              i_enable,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [31:0]       i_rd_data,
  output logic              o_match,
  output logic              o_hit,
  output logic [3:0]        o_lanes,
  output logic [31:0]       o_replace
);

  slot_t       r_slot;
  logic [4:0]  w_shift;
  logic [31:0] w_bmask;
  logic [31:0] w_cmp_sh;
  logic        w_cmp_ok;

  always_ff @(posedge clk_sys) begin
    if (!reset_n || i_clear) begin
      r_slot <= '0;
    end else if (i_wr) begin
      r_slot.valid   <= 1'b1;
      r_slot.addr    <= i_code_addr;
      r_slot.width   <= i_code_width;
      r_slot.cmp_en  <= i_code_cmp_en;
      r_slot.compare <= i_code_compare;
      r_slot.replace <= i_code_replace;
    end
  end

  always_comb begin
    o_lanes   = lanemask(r_slot.width, r_slot.addr[1:0]);
    w_shift   = lane_shift(r_slot.width, r_slot.addr[1:0]);
    w_bmask   = byte_mask(o_lanes);
    w_cmp_sh  = r_slot.compare << w_shift;
    o_replace = r_slot.replace << w_shift;
    w_cmp_ok  = !r_slot.cmp_en || ((i_rd_data & w_bmask) == (w_cmp_sh & w_bmask));
    o_hit     = r_slot.valid && i_enable &&
                (r_slot.addr[ADDR_W+1:2] == i_rd_addr) && w_cmp_ok;
    o_match   = r_slot.valid && (r_slot.addr == i_code_addr) &&
                (r_slot.width == i_code_width);
  end

endmodule

// File: rtl/gba_cheat_engine.sv
// gba_cheat_engine: patches ROM read data on its way to the GBA core.
//   clk_sys, reset_n : clock, synchronous active-low reset
//   enable           : global cheat enable (0 = pass-through, same latency)
//   clear            : pulse, empties the code table and sticky flags
//   code_in          : {clk, flags, addr, compare, replace}; load on clk rise
//   rd (slave)       : read-return beat in, patched beat out (2-cycle latency)
//   code_count       : occupied slots
//   overflow, reject : sticky drop indicators
// Per-lane winner selection happens before the S1 register, so a beat carries
// its own snapshot of the table into S2; later loads/clears cannot affect it.
module gba_cheat_engine
  import gba_cheat_pkg::*;
#(
  parameter int NUM_CODES = 32,
  parameter int ADDR_W    = 26
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [128:0]               code_in,
  gba_cheat_engine_if.slave          rd,
  output logic [$clog2(NUM_CODES):0] code_count,
  output logic                       overflow,
  output logic                       reject
);

  localparam int CNT_W = $clog2(NUM_CODES) + 1;

  // Load path
  logic             r_clk_d;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_reject;

  logic             w_load;
  logic [27:0]      w_code_addr;
  cw_e              w_code_width;
  logic             w_code_cmp_en;
  logic [31:0]      w_code_cmp;
  logic [31:0]      w_code_rep;
  logic             w_bad;
  logic             w_full;
  logic             w_any_match;
  logic             w_accept;
  logic [NUM_CODES-1:0] w_match;
  logic [NUM_CODES-1:0] w_hit;
  logic [NUM_CODES-1:0] w_wr;
  logic [3:0]       w_lanes [NUM_CODES];
  logic [31:0]      w_rep   [NUM_CODES];
  logic             w_unused_ok;

  // Pipeline
  logic        r_s1_valid;
  logic [31:0] r_s1_data;
  logic [3:0]  r_s1_lane_hit;
  logic [31:0] r_s1_lane_rep;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [3:0]  w_lane_hit;
  logic [31:0] w_lane_rep;
  logic [31:0] w_merged;

  assign w_load        = code_in[CODE_CLK] & ~r_clk_d;
  assign w_code_addr   = code_in[CODE_ADDR_LSB +: 28];
  assign w_code_width  = cw_e'(code_in[CODE_FLAGS_LSB + FLAG_W_LSB +: 2]);
  assign w_code_cmp_en = code_in[CODE_FLAGS_LSB + FLAG_CMP_EN];
  assign w_code_cmp    = code_in[CODE_CMP_LSB +: 32];
  assign w_code_rep    = code_in[CODE_REP_LSB +: 32];
  assign w_unused_ok   = &{1'b0, code_in[127:99], code_in[95:92]};

  always_comb begin
    case (w_code_width)
      CW_HALF: w_bad = w_code_addr[0];
      CW_WORD: w_bad = (w_code_addr[1:0] != 2'b00);
      CW_BAD:  w_bad = 1'b1;
      default: w_bad = 1'b0;
    endcase
  end

  assign w_full      = (r_count == CNT_W'(NUM_CODES));
  assign w_any_match = |w_match;
  assign w_accept    = w_load && !clear && !w_bad;

  // An existing entry with the same address/width is rewritten in place;
  // otherwise the next free slot (index == count) is filled.
  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NUM_CODES; i++) begin
      if (w_accept) begin
        if (w_any_match) w_wr[i] = w_match[i];
        else             w_wr[i] = !w_full && (r_count == CNT_W'(i));
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) r_clk_d <= 1'b0;
    else          r_clk_d <= code_in[CODE_CLK];
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n || clear) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_reject   <= 1'b0;
    end else if (w_load) begin
      if (w_bad)             r_reject   <= 1'b1;
      else if (!w_any_match) begin
        if (w_full)          r_overflow <= 1'b1;
        else                 r_count    <= r_count + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CODES; g++) begin : g_slot
    gba_cheat_slot #(.ADDR_W(ADDR_W)) u_slot (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .i_clear        (clear),
      .i_wr           (w_wr[g]),
      .i_code_addr    (w_code_addr),
      .i_code_width   (w_code_width),
      .i_code_cmp_en  (w_code_cmp_en),
      .i_code_compare (w_code_cmp),
      .i_code_replace (w_code_rep),
      .i_enable       (enable),
      .i_rd_addr      (rd.rd_addr),
      .i_rd_data      (rd.rd_data),
      .o_match        (w_match[g]),
      .o_hit          (w_hit[g]),
      .o_lanes        (w_lanes[g]),
      .o_replace      (w_rep[g])
    );
  end

  // Ascending scan: the highest-index hitting slot is the last writer.
  always_comb begin
    w_lane_hit = '0;
    w_lane_rep = '0;
    for (int i = 0; i < NUM_CODES; i++) begin
      for (int l = 0; l < 4; l++) begin
        if (w_hit[i] && w_lanes[i][l]) begin
          w_lane_hit[l]        = 1'b1;
          w_lane_rep[8*l +: 8] = w_rep[i][8*l +: 8];
        end
      end
    end
  end

  always_comb begin
    w_merged = r_s1_data;
    for (int l = 0; l < 4; l++) begin
      if (r_s1_lane_hit[l]) w_merged[8*l +: 8] = r_s1_lane_rep[8*l +: 8];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_data     <= '0;
      r_s1_lane_hit <= '0;
      r_s1_lane_rep <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
    end else begin
      r_s1_valid <= rd.rd_valid;
      if (rd.rd_valid) begin
        r_s1_data     <= rd.rd_data;
        r_s1_lane_hit <= w_lane_hit;
        r_s1_lane_rep <= w_lane_rep;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_out_data <= w_merged;
    end
  end

  assign rd.out_valid = r_out_valid;
  assign rd.out_data  = r_out_data;
  assign code_count   = r_count;
  assign overflow     = r_overflow;
  assign reject       = r_reject;

endmodule

// File: tb/tb_gba_cheat_engine.sv
// Directed bench for gba_cheat_engine (NUM_CODES=32, ADDR_W=26).
module tb_gba_cheat_engine;

  localparam int NUM_CODES = 32;
  localparam int ADDR_W    = 26;

  logic         clk_sys = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable  = 1'b1;
  logic         clear   = 1'b0;
  logic [128:0] code_in = '0;
  logic [5:0]   code_count;
  logic         overflow;
  logic         reject;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] exp_q [$];

  gba_cheat_engine_if #(.ADDR_W(ADDR_W)) rd_if ();

  gba_cheat_engine #(.NUM_CODES(NUM_CODES), .ADDR_W(ADDR_W)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .code_in    (code_in),
    .rd         (rd_if.slave),
    .code_count (code_count),
    .overflow   (overflow),
    .reject     (reject)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  initial begin
    rd_if.rd_valid = 1'b0;
    rd_if.rd_addr  = '0;
    rd_if.rd_data  = '0;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic load_code(input logic [1:0] w, input logic ce, input logic [31:0] addr,
                           input logic [31:0] cmp, input logic [31:0] rep);
    tick();
    code_in = {1'b1, 29'd0, w, ce, addr, cmp, rep};
    tick();
    code_in[128] = 1'b0;
  endtask

  task automatic pulse_clear();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // One isolated beat; returns out_valid one cycle after capture (should be 0)
  // and out_valid/out_data two cycles after the beat was driven.
  task automatic send_beat(input logic [31:0] byte_addr, input logic [31:0] data,
                           output logic early_valid, output logic got_valid,
                           output logic [31:0] got_data);
    logic [31:0] sh;
    sh = byte_addr >> 2;
    tick();
    rd_if.rd_valid = 1'b1;
    rd_if.rd_addr  = sh[ADDR_W-1:0];
    rd_if.rd_data  = data;
    tick();
    rd_if.rd_valid = 1'b0;
    early_valid = rd_if.out_valid;
    tick();
    got_valid = rd_if.out_valid;
    got_data  = rd_if.out_data;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_total++;
    if (rd_if.out_valid !== 1'b0 || rd_if.out_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_out: valid=%b data=%h required valid=0 data=0", rd_if.out_valid, rd_if.out_data);
    end
    n_total++;
    if (code_count !== 6'd0 || overflow !== 1'b0 || reject !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_table: count=%0d ovf=%b rej=%b required 0/0/0", code_count, overflow, reject);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_word_patch();
    logic ev, v;
    logic [31:0] d;
    load_code(2'd2, 1'b0, 32'h0800_0100, 32'h0, 32'hDEAD_BEEF);
    n_total++;
    if (code_count !== 6'd1) begin
      n_bad++;
      $display("FAIL word_count: got %0d required 1", code_count);
    end
    send_beat(32'h0800_0100, 32'h1122_3344, ev, v, d);
    n_total++;
    if (ev !== 1'b0 || v !== 1'b1 || d !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL word_hit: early=%b valid=%b data=%h required 0/1/deadbeef", ev, v, d);
    end
    send_beat(32'h0800_0104, 32'h1122_3344, ev, v, d);
    n_total++;
    if (v !== 1'b1 || d !== 32'h1122_3344) begin
      n_bad++;
      $display("FAIL word_miss: valid=%b data=%h required 1/11223344", v, d);
    end
  endtask

  task automatic test_byte_compare();
    logic ev, v;
    logic [31:0] d;
    load_code(2'd0, 1'b1, 32'h0800_0203, 32'h44, 32'h99);
    send_beat(32'h0800_0203, 32'h4433_2211, ev, v, d);
    n_total++;
    if (v !== 1'b1 || d !== 32'h9933_2211) begin
      n_bad++;
      $display("FAIL byte_cmp_hit: valid=%b data=%h required 1/99332211", v, d);
    end
    send_beat(32'h0800_0203, 32'h5533_2211, ev, v, d);
    n_total++;
    if (v !== 1'b1 || d !== 32'h5533_2211) begin
      n_bad++;
      $display("FAIL byte_cmp_miss: valid=%b data=%h required 1/55332211", v, d);
    end
  endtask

  task automatic test_overflow();
    logic ev, v;
    logic [31:0] d;
    pulse_clear();
    for (int i = 0; i <= NUM_CODES; i++)
      load_code(2'd2, 1'b0, 32'h0800_1000 + 32'(4 * i), 32'h0, 32'(i));
    tick();
    n_total++;
    if (code_count !== 6'd32 || overflow !== 1'b1 || reject !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_flags: count=%0d ovf=%b rej=%b required 32/1/0", code_count, overflow, reject);
    end
    send_beat(32'h0800_107C, 32'h0, ev, v, d);
    n_total++;
    if (d !== 32'h0000_001F) begin
      n_bad++;
      $display("FAIL ovf_last_slot: data=%h required 0000001f", d);
    end
    send_beat(32'h0800_1080, 32'h7777_7777, ev, v, d);
    n_total++;
    if (d !== 32'h7777_7777) begin
      n_bad++;
      $display("FAIL ovf_dropped: data=%h required 77777777", d);
    end
    load_code(2'd2, 1'b0, 32'h0800_1014, 32'h0, 32'hCAFE_F00D);
    send_beat(32'h0800_1014, 32'h0, ev, v, d);
    n_total++;
    if (code_count !== 6'd32 || d !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL ovf_overwrite: count=%0d data=%h required 32/cafef00d", code_count, d);
    end
    pulse_clear();
    n_total++;
    if (code_count !== 6'd0 || overflow !== 1'b0 || reject !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_flags: count=%0d ovf=%b rej=%b required 0/0/0", code_count, overflow, reject);
    end
    send_beat(32'h0800_1014, 32'h1234_5678, ev, v, d);
    n_total++;
    if (d !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL clear_passthru: data=%h required 12345678", d);
    end
  endtask

  task automatic test_priority();
    logic ev, v;
    logic [31:0] d;
    load_code(2'd1, 1'b0, 32'h0800_0001, 32'h0, 32'h5555);
    tick();
    n_total++;
    if (reject !== 1'b1 || code_count !== 6'd0) begin
      n_bad++;
      $display("FAIL reject_half: rej=%b count=%0d required 1/0", reject, code_count);
    end
    load_code(2'd2, 1'b0, 32'h0800_0004, 32'h0, 32'h1122_3344);
    load_code(2'd0, 1'b0, 32'h0800_0005, 32'h0, 32'h0000_00AB);
    load_code(2'd2, 1'b0, 32'h0800_0006, 32'h0, 32'hFFFF_FFFF);
    tick();
    n_total++;
    if (code_count !== 6'd2 || reject !== 1'b1) begin
      n_bad++;
      $display("FAIL prio_count: count=%0d rej=%b required 2/1", code_count, reject);
    end
    send_beat(32'h0800_0004, 32'hFFFF_FFFF, ev, v, d);
    n_total++;
    if (v !== 1'b1 || d !== 32'h1122_AB44) begin
      n_bad++;
      $display("FAIL prio_merge: valid=%b data=%h required 1/1122ab44", v, d);
    end
  endtask

  // Scoreboard-driven stream: expected values queued at drive time,
  // popped as out_valid beats appear.
  task automatic test_back_to_back();
    logic [31:0] exp_d;
    int seen;
    seen = 0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      n_total++;
      if (k >= 2 && k < 10) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        if (rd_if.out_valid !== 1'b1 || rd_if.out_data !== exp_d) begin
          n_bad++;
          $display("FAIL b2b_beat%0d: valid=%b data=%h required 1/%h", k - 2, rd_if.out_valid, rd_if.out_data, exp_d);
        end else seen++;
      end else if (rd_if.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_idle%0d: valid=%b required 0", k, rd_if.out_valid);
      end
      if (k < 8) begin
        enable         = (k < 4);
        rd_if.rd_valid = 1'b1;
        rd_if.rd_addr  = 26'h200_0001;
        rd_if.rd_data  = 32'(k);
        exp_q.push_back((k < 4) ? 32'h1122_AB44 : 32'(k));
      end else begin
        rd_if.rd_valid = 1'b0;
        enable         = 1'b1;
      end
    end
    n_total++;
    if (seen !== 8) begin
      n_bad++;
      $display("FAIL b2b_run: contiguous=%0d required 8", seen);
    end
  endtask

  task automatic test_reset_mid_stream();
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 3) begin
        n_total++;
        if (rd_if.out_valid !== 1'b1 || rd_if.out_data !== 32'h1122_AB44) begin
          n_bad++;
          $display("FAIL rst_pre: valid=%b data=%h required 1/1122ab44", rd_if.out_valid, rd_if.out_data);
        end
      end
      if (k == 4) begin
        n_total++;
        if (rd_if.out_valid !== 1'b0 || rd_if.out_data !== 32'h0 || code_count !== 6'd0) begin
          n_bad++;
          $display("FAIL rst_flush: valid=%b data=%h count=%0d required 0/0/0", rd_if.out_valid, rd_if.out_data, code_count);
        end
      end
      if (k >= 5) begin
        n_total++;
        if (rd_if.out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rst_stale%0d: valid=%b required 0", k, rd_if.out_valid);
        end
      end
      if (k < 3) begin
        rd_if.rd_valid = 1'b1;
        rd_if.rd_addr  = 26'h200_0001;
        rd_if.rd_data  = 32'hA5A5_0000 + 32'(k);
      end else begin
        rd_if.rd_valid = 1'b0;
      end
      reset_n = (k != 3);
    end
  endtask

  initial begin
    test_reset();
    test_word_patch();
    test_byte_compare();
    test_overflow();
    test_priority();
    test_back_to_back();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
